// File: rtl/key_filter.sv
// key_filter: debounces an active-low bouncy push-button into a one-cycle event flag plus a stable level.
module key_filter #(
  parameter int CNT_MAX = 999_999,
  parameter int CNT_W   = 20
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state
);
  typedef enum logic [1:0] {IDLE, FILT_DN, DOWN, FILT_UP} state_t;
  state_t state, state_nx;
  logic s1, s2, s3;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic flag_nx, level_nx;
  logic nedge, pedge, done;
  assign nedge = s3 & ~s2;
  assign pedge = ~s3 & s2;
  assign done = cnt == CNT_W'(CNT_MAX - 1);
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      key_flag <= 1'b0;
      key_state <= 1'b1;
    end else begin
      s1 <= key_in;
      s2 <= s1;
      s3 <= s2;
      state <= state_nx;
      cnt <= cnt_nx;
      key_flag <= flag_nx;
      key_state <= level_nx;
    end
  end
  // Counter is zero on every state entry, so it can never run past CNT_MAX-1.
  always_comb begin
    state_nx = state;
    cnt_nx = '0;
    flag_nx = 1'b0;
    level_nx = key_state;
    case (state)
      IDLE: state_nx = nedge ? FILT_DN : IDLE;
      FILT_DN:
        if (pedge) state_nx = IDLE;
        else if (done) begin
          state_nx = DOWN;
          flag_nx = 1'b1;
          level_nx = 1'b0;
        end else cnt_nx = cnt + 1'b1;
      DOWN: state_nx = pedge ? FILT_UP : DOWN;
      FILT_UP:
        if (nedge) state_nx = DOWN;
        else if (done) begin
          state_nx = IDLE;
          flag_nx = 1'b1;
          level_nx = 1'b1;
        end else cnt_nx = cnt + 1'b1;
      default: state_nx = IDLE;
    endcase
  end
endmodule
